// File: rtl/Qupls4_pkg.sv
// Shared Qupls4 definitions: ROB sizing, functional-unit codes and the
// reservation-station entry format exchanged between dispatcher and stations.
package Qupls4_pkg;

    localparam int ROB_ENTRIES = 16;
    typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_ndx_t;

    localparam logic [3:0] FU_SAU0  = 4'd0;
    localparam logic [3:0] FU_SAU1  = 4'd1;
    localparam logic [3:0] FU_MUL   = 4'd2;
    localparam logic [3:0] FU_DIV   = 4'd3;
    localparam logic [3:0] FU_BRC   = 4'd4;
    localparam logic [3:0] FU_LOAD  = 4'd5;
    localparam logic [3:0] FU_STORE = 4'd6;
    localparam logic [3:0] FU_AGEN  = 4'd7;
    localparam logic [3:0] FU_CSR   = 4'd8;
    localparam logic [3:0] FU_FMA0  = 4'd9;
    localparam logic [3:0] FU_FMA1  = 4'd10;
    localparam logic [3:0] FU_VEC   = 4'd11;
    localparam logic [3:0] FU_FPU   = 4'd12;
    localparam logic [3:0] FU_NONE  = 4'd15;

    typedef enum logic [1:0] {
        RS_EMPTY   = 2'd0,
        RS_WAITING = 2'd1,
        RS_READY   = 2'd2
    } rs_state_t;

    // An arg whose _v bit is clear carries its physical-register tag in [8:0].
    typedef struct packed {
        logic [31:0] ins;
        logic [3:0]  funcunit;
        rob_ndx_t    rndx;
        logic        argA_v;
        logic [63:0] argA;
        logic        argB_v;
        logic [63:0] argB;
        logic        argC_v;
        logic [63:0] argC;
        logic        argD_v;
        logic [63:0] argD;
    } reservation_station_entry_t;

endpackage

// File: rtl/qupls4_rs_oldest_ready.sv
// Age-ordered picker: among requesting entries returns the one whose age lies
// furthest behind the reference sequence number (modular distance).
module qupls4_rs_oldest_ready #(
    parameter int N  = 4,
    parameter int AW = 5
) (
    input  logic [N-1:0]         i_req,
    input  logic [N-1:0][AW-1:0] i_age,
    input  logic [AW-1:0]        i_ref,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);

    logic [AW-1:0] w_dist;
    logic [AW-1:0] w_best;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_best  = '0;
        w_dist  = '0;
        for (int i = 0; i < N; i++) begin
            w_dist = i_ref - i_age[i];
            if (i_req[i] && (!o_found || (w_dist > w_best))) begin
                o_found = 1'b1;
                o_idx   = ($clog2(N))'(i);
                w_best  = w_dist;
            end
        end
    end

endmodule

// File: rtl/qupls4_reservation_station.sv
// Reservation station for one functional unit: accepts dispatched entries,
// snoops write-back buses for missing operands and issues the oldest ready op.
module qupls4_reservation_station
    import Qupls4_pkg::*;
#(
    parameter logic [3:0] FUNCUNIT = 4'd0,
    parameter int          NENTRIES = 4,
    parameter int          NWB      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  reservation_station_entry_t [3:0]  rse_i,
    input  logic [3:0]                        rse_v,
    input  logic [ROB_ENTRIES-1:0]            stomp,
    input  logic [NWB-1:0]                    wb_v,
    input  logic [NWB-1:0][8:0]               wb_preg,
    input  logic [NWB-1:0][63:0]              wb_data,
    input  logic                              fu_ready,
    output reservation_station_entry_t        issue_o,
    output logic                              issue_v,
    output logic                              busy,
    output logic                              err
);

    localparam int IW = $clog2(NENTRIES);
    localparam int CW = $clog2(NENTRIES + 1);

    rs_state_t                  r_state [NENTRIES];
    reservation_station_entry_t r_ent   [NENTRIES];
    logic [NENTRIES-1:0][4:0]   r_age;
    logic [4:0]                 r_seq;
    reservation_station_entry_t r_issue_o;
    logic                       r_issue_v;
    logic                       r_busy;
    logic                       r_err;

    rs_state_t                  w_state_n [NENTRIES];
    reservation_station_entry_t w_ent_n   [NENTRIES];
    reservation_station_entry_t w_ins;
    logic [3:0]                 w_match;
    logic [1:0]                 w_lane;
    logic                       w_lane_hit;
    logic                       w_multi;
    logic                       w_ins_stomp;
    logic                       w_ins_here;
    logic                       w_drop;
    logic                       w_free_found;
    logic [IW-1:0]              w_free_idx;
    logic [NENTRIES-1:0]        w_cand;
    logic [IW-1:0]              w_pick;
    logic                       w_pick_found;
    logic                       w_issue;
    logic [CW-1:0]              w_nfree;

    // Lowest-numbered matching bus wins, so scan from the top down.
    function automatic logic [64:0] wake_arg(input logic v, input logic [63:0] a);
        logic [64:0] r;
        r = {v, a};
        if (!v) begin
            for (int i = NWB - 1; i >= 0; i--) begin
                if (wb_v[i] && (wb_preg[i] == a[8:0]))
                    r = {1'b1, wb_data[i]};
            end
        end
        return r;
    endfunction

    function automatic reservation_station_entry_t wake_ent(input reservation_station_entry_t e);
        reservation_station_entry_t r;
        r = e;
        {r.argA_v, r.argA} = wake_arg(e.argA_v, e.argA);
        {r.argB_v, r.argB} = wake_arg(e.argB_v, e.argB);
        {r.argC_v, r.argC} = wake_arg(e.argC_v, e.argC);
        {r.argD_v, r.argD} = wake_arg(e.argD_v, e.argD);
        return r;
    endfunction

    function automatic logic all_valid(input reservation_station_entry_t e);
        return e.argA_v & e.argB_v & e.argC_v & e.argD_v;
    endfunction

    always_comb begin
        w_match      = '0;
        w_lane       = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_cand       = '0;
        for (int k = 0; k < 4; k++)
            w_match[k] = rse_v[k] && (rse_i[k].funcunit == FUNCUNIT) && (FUNCUNIT != FU_NONE);
        for (int k = 3; k >= 0; k--)
            if (w_match[k]) w_lane = 2'(k);
        w_lane_hit = |w_match;
        w_multi    = |(w_match & (w_match - 4'd1));
        // Free slot is taken from start-of-cycle state only.
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (r_state[i] == RS_EMPTY) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
        end
        for (int i = 0; i < NENTRIES; i++)
            w_cand[i] = (r_state[i] == RS_READY) && !stomp[r_ent[i].rndx];
        w_ins       = wake_ent(rse_i[w_lane]);
        w_ins_stomp = stomp[w_ins.rndx];
    end

    assign w_ins_here = w_lane_hit && w_free_found;
    assign w_drop     = w_lane_hit && !w_free_found && !w_ins_stomp;

    qupls4_rs_oldest_ready #(
        .N  (NENTRIES),
        .AW (5)
    ) u_pick (
        .i_req   (w_cand),
        .i_age   (r_age),
        .i_ref   (r_seq),
        .o_idx   (w_pick),
        .o_found (w_pick_found)
    );

    assign w_issue = fu_ready && w_pick_found;

    always_comb begin
        w_nfree = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            w_ent_n[i]   = wake_ent(r_ent[i]);
            w_state_n[i] = r_state[i];
            if ((r_state[i] == RS_WAITING) && all_valid(w_ent_n[i]))
                w_state_n[i] = RS_READY;
            if (w_issue && (w_pick == IW'(i)))
                w_state_n[i] = RS_EMPTY;
            if ((r_state[i] != RS_EMPTY) && stomp[r_ent[i].rndx])
                w_state_n[i] = RS_EMPTY;
            if (w_ins_here && (w_free_idx == IW'(i))) begin
                w_ent_n[i] = w_ins;
                if (w_ins_stomp)
                    w_state_n[i] = RS_EMPTY;
                else if (all_valid(w_ins))
                    w_state_n[i] = RS_READY;
                else
                    w_state_n[i] = RS_WAITING;
            end
            if (w_state_n[i] == RS_EMPTY)
                w_nfree = w_nfree + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NENTRIES; i++)
                r_state[i] <= RS_EMPTY;
            r_seq     <= '0;
            r_issue_v <= 1'b0;
            r_issue_o <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            for (int i = 0; i < NENTRIES; i++)
                r_state[i] <= w_state_n[i];
            if (w_ins_here)
                r_seq <= r_seq + 5'd1;
            r_issue_v <= w_issue;
            if (w_issue)
                r_issue_o <= r_ent[w_pick];
            // One slot is kept in reserve for a dispatch already in flight.
            r_busy <= (w_nfree <= CW'(1));
            if (w_multi || w_drop)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NENTRIES; i++)
            r_ent[i] <= w_ent_n[i];
        if (w_ins_here)
            r_age[w_free_idx] <= r_seq;
    end

    assign issue_o = r_issue_o;
    assign issue_v = r_issue_v;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule

// File: tb/tb_qupls4_reservation_station.sv
// Bench for qupls4_reservation_station: lane-filter vector table, scoreboard of
// expected issues, and directed sequences for wakeup, fill, age order and stomp.
module tb_qupls4_reservation_station;
    import Qupls4_pkg::*;

    localparam logic [3:0] FU = 4'd2;

    logic                             clk;
    logic                             rst;
    reservation_station_entry_t [3:0] rse_i;
    logic [3:0]                       rse_v;
    logic [ROB_ENTRIES-1:0]           stomp;
    logic [3:0]                       wb_v;
    logic [3:0][8:0]                  wb_preg;
    logic [3:0][63:0]                 wb_data;
    logic                             fu_ready;
    reservation_station_entry_t       issue_o;
    logic                             issue_v;
    logic                             busy;
    logic                             err;

    qupls4_reservation_station #(
        .FUNCUNIT (FU),
        .NENTRIES (4),
        .NWB      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rse_i    (rse_i),
        .rse_v    (rse_v),
        .stomp    (stomp),
        .wb_v     (wb_v),
        .wb_preg  (wb_preg),
        .wb_data  (wb_data),
        .fu_ready (fu_ready),
        .issue_o  (issue_o),
        .issue_v  (issue_v),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        rob_ndx_t    rndx;
        logic [63:0] argB;
    } sb_t;

    typedef struct {
        logic [3:0] fu;
        int         lane;
        rob_ndx_t   rndx;
        logic       exp_issue;
    } vec_t;

    sb_t sbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic reservation_station_entry_t mk(input rob_ndx_t r, input logic [3:0] fu,
                                                      input logic bv, input logic [8:0] tag);
        reservation_station_entry_t e;
        e          = '0;
        e.ins      = 32'h1000 + 32'(r);
        e.funcunit = fu;
        e.rndx     = r;
        e.argA_v   = 1'b1;
        e.argA     = 64'h11;
        e.argB_v   = bv;
        e.argB     = bv ? 64'(100 + int'(r)) : 64'(tag);
        e.argC_v   = 1'b1;
        e.argC     = 64'h33;
        e.argD_v   = 1'b1;
        e.argD     = 64'h44;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input rob_ndx_t r, input logic [63:0] b);
        sbq.push_back('{r, b});
    endtask

    task automatic disp(input int lane, input reservation_station_entry_t e);
        rse_i[lane] = e;
        rse_v[lane] = 1'b1;
    endtask

    task automatic wb1(input logic [8:0] tag, input logic [63:0] d);
        wb_v       = 4'b0001;
        wb_preg[0] = tag;
        wb_data[0] = d;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rse_v    = '0;
        rse_i    = '0;
        stomp    = '0;
        wb_v     = '0;
        wb_preg  = '0;
        wb_data  = '0;
        fu_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard consumer: every issue must match the next expected entry.
    always @(negedge clk) begin
        if (issue_v && !rst) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_issue: got rndx %0d expected no issue at %0t", issue_o.rndx, $time);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check("sb_rndx", 64'(issue_o.rndx), 64'(e.rndx));
                check("sb_argB", issue_o.argB, e.argB);
                check("sb_args_v", {60'd0, issue_o.argA_v, issue_o.argB_v, issue_o.argC_v, issue_o.argD_v}, 64'hF);
            end
        end
    end

    vec_t vt[6];

    initial begin
        vt[0] = '{FU,      2, 4'd1, 1'b1};
        vt[1] = '{FU_NONE, 0, 4'd2, 1'b0};
        vt[2] = '{FU_LOAD, 1, 4'd3, 1'b0};
        vt[3] = '{FU,      0, 4'd4, 1'b1};
        vt[4] = '{FU_SAU0, 3, 4'd5, 1'b0};
        vt[5] = '{FU,      3, 4'd6, 1'b1};

        do_reset();
        check("rst_issue_v", 64'(issue_v), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_issue_o_zero", 64'(issue_o == '0), 64'd1);

        // Lane filtering and single-op latency.
        fu_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            disp(vt[v].lane, mk(vt[v].rndx, vt[v].fu, 1'b1, 9'd0));
            if (vt[v].exp_issue) push(vt[v].rndx, 64'(100 + int'(vt[v].rndx)));
            step();
            rse_v = '0;
            check("vec_early", 64'(issue_v), 64'd0);
            step();
            check("vec_issue", 64'(issue_v), 64'(vt[v].exp_issue));
            check("vec_busy", 64'(busy), 64'd0);
            check("vec_err", 64'(err), 64'd0);
            step();
            check("vec_single", 64'(issue_v), 64'd0);
        end

        // Operand wakeup after a hold, lowest matching bus wins.
        push(4'd9, 64'hDEAD);
        disp(1, mk(4'd9, FU, 1'b0, 9'd37));
        step();
        rse_v = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wake_hold", 64'(issue_v), 64'd0);
        end
        wb_v       = 4'b0111;
        wb_preg[0] = 9'd36;
        wb_data[0] = 64'h1111;
        wb_preg[1] = 9'd37;
        wb_data[1] = 64'hDEAD;
        wb_preg[2] = 9'd37;
        wb_data[2] = 64'hBEEF;
        step();
        wb_v = '0;
        check("wake_c1", 64'(issue_v), 64'd0);
        step();
        check("wake_c2", 64'(issue_v), 64'd1);
        check("wake_argB", issue_o.argB, 64'hDEAD);

        // Write-back in the insert cycle.
        push(4'd10, 64'hDEAD);
        disp(0, mk(4'd10, FU, 1'b0, 9'd37));
        wb_v = 4'b0110;
        step();
        rse_v = '0;
        wb_v  = '0;
        check("byp_c1", 64'(issue_v), 64'd0);
        step();
        check("byp_c2", 64'(issue_v), 64'd1);
        step();

        // Fill to capacity with the unit stalled, then drain in age order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(0, mk(rob_ndx_t'(i + 1), FU, 1'b1, 9'd0));
            step();
            check("fill_busy", 64'(busy), 64'(i >= 2));
            check("fill_err", 64'(err), 64'd0);
        end
        disp(0, mk(4'd5, FU, 1'b1, 9'd0));
        step();
        rse_v = '0;
        check("drop_err", 64'(err), 64'd1);
        check("drop_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) push(rob_ndx_t'(i + 1), 64'(101 + i));
        fu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_v", 64'(issue_v), 64'd1);
        end
        step();
        check("drain_done", 64'(issue_v), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);

        // Age order: readiness order first, then age among simultaneous ready.
        do_reset();
        fu_ready = 1'b1;
        disp(3, mk(4'd1, FU, 1'b0, 9'd10));
        step();
        disp(3, mk(4'd2, FU, 1'b0, 9'd11));
        step();
        disp(3, mk(4'd3, FU, 1'b0, 9'd12));
        step();
        rse_v = '0;
        push(4'd3, 64'hC0C0);
        wb1(9'd12, 64'hC0C0);
        step();
        wb_v = '0;
        step();
        step();
        push(4'd1, 64'hA0A0);
        wb1(9'd10, 64'hA0A0);
        step();
        wb_v = '0;
        step();
        step();
        // New youngest entry lands in a lower slot than the older waiter.
        disp(0, mk(4'd4, FU, 1'b0, 9'd11));
        step();
        rse_v = '0;
        push(4'd2, 64'hB0B0);
        push(4'd4, 64'hB0B0);
        wb1(9'd11, 64'hB0B0);
        step();
        wb_v = '0;
        step();
        check("age_first", 64'(issue_v), 64'd1);
        step();
        check("age_second", 64'(issue_v), 64'd1);
        step();
        check("age_idle", 64'(issue_v), 64'd0);

        // Stomp a ready entry as fu_ready rises.
        do_reset();
        disp(0, mk(4'd5, FU, 1'b1, 9'd0));
        step();
        disp(0, mk(4'd6, FU, 1'b0, 9'd30));
        step();
        disp(0, mk(4'd7, FU, 1'b0, 9'd31));
        step();
        rse_v = '0;
        check("stomp_pre_busy", 64'(busy), 64'd1);
        stomp[5] = 1'b1;
        fu_ready = 1'b1;
        step();
        stomp = '0;
        check("stomp_no_issue", 64'(issue_v), 64'd0);
        check("stomp_busy", 64'(busy), 64'd0);
        step();
        check("stomp_freed", 64'(issue_v), 64'd0);
        push(4'd6, 64'h6666);
        push(4'd7, 64'h7777);
        wb_v       = 4'b0011;
        wb_preg[0] = 9'd30;
        wb_data[0] = 64'h6666;
        wb_preg[1] = 9'd31;
        wb_data[1] = 64'h7777;
        step();
        wb_v = '0;
        step();
        step();
        step();

        // Stomp of the inserting lane drops it silently.
        disp(2, mk(4'd8, FU, 1'b1, 9'd0));
        stomp[8] = 1'b1;
        step();
        rse_v = '0;
        stomp = '0;
        step();
        check("stomp_ins_v", 64'(issue_v), 64'd0);
        check("stomp_ins_err", 64'(err), 64'd0);
        step();

        // Two matching lanes: lane 0 wins, err sets.
        push(4'd12, 64'(112));
        disp(0, mk(4'd12, FU, 1'b1, 9'd0));
        disp(1, mk(4'd13, FU, 1'b1, 9'd0));
        step();
        rse_v = '0;
        check("multi_err", 64'(err), 64'd1);
        step();
        check("multi_issue", 64'(issue_v), 64'd1);
        step();
        check("multi_one", 64'(issue_v), 64'd0);
        step();

        // Reset mid-operation discards stored entries.
        fu_ready = 1'b0;
        disp(0, mk(4'd14, FU, 1'b1, 9'd0));
        step();
        rse_v = '0;
        rst   = 1'b1;
        step();
        rst      = 1'b0;
        fu_ready = 1'b1;
        check("rstmid_err", 64'(err), 64'd0);
        step();
        step();
        check("rstmid_v", 64'(issue_v), 64'd0);
        step();

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
